cpu6_store_buffer: RTL and testbench

Posted-write store buffer between the cpu6_core data port and data memory. Each `memwriteM` store is captured in a small FIFO in one cycle, and the core is never held for a slow memory write. Entries drain in order to a valid/ready memory write port. Loads are served from the youngest buffered store to the same word when one exists, otherwise from memory, so the core keeps its combinational `readdata` view.

---
 rtl/cpu6_store_buffer_if.sv | 30 +++
 rtl/cpu6_store_buffer.sv | 95 +++++++++
 tb/tb_cpu6_store_buffer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/cpu6_store_buffer_if.sv
// Memory-side write and load port of the cpu6 store buffer.
// The master end is the store buffer; the slave end is the data memory.
interface cpu6_store_buffer_if #(
  parameter int XLEN = 32
);
  logic            mem_wvalid;
  logic            mem_wready;
  logic [XLEN-1:0] mem_waddr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_raddr;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_wvalid,
    output mem_waddr,
    output mem_wdata,
    output mem_raddr,
    input  mem_wready,
    input  mem_rdata
  );

  modport slave (
    input  mem_wvalid,
    input  mem_waddr,
    input  mem_wdata,
    input  mem_raddr,
    output mem_wready,
    output mem_rdata
  );
endinterface

// File: rtl/cpu6_store_buffer.sv
// Posted-write store buffer: cpu6 core stores enter an in-order FIFO and drain to memory,
// while loads are forwarded from the youngest buffered store to the same word.
module cpu6_store_buffer #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 memwriteM,
  input  logic [XLEN-1:0]      dataaddr,
  input  logic [XLEN-1:0]      writedata,
  output logic [XLEN-1:0]      readdata,
  output logic                 sb_full,
  output logic                 sb_empty,
  output logic                 sb_overflow,
  cpu6_store_buffer_if.master  mem
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [XLEN-1:0] addr_q [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [AW-1:0]   wp;
  logic [AW-1:0]   rp;
  logic [CW-1:0]   count;
  logic            overflow_q;

  logic            deq;
  logic            enq;
  logic            fwd_hit;
  logic [XLEN-1:0] fwd_data;
  logic [AW-1:0]   fwd_idx;

  // A full buffer still accepts a store when the head leaves on the same edge.
  assign deq = (count != '0) && mem.mem_wready;
  assign enq = memwriteM && ((count != CNT_FULL) || deq);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      wp         <= '0;
      rp         <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (enq) begin
        addr_q[wp] <= dataaddr;
        data_q[wp] <= writedata;
        wp         <= wp + PTR_ONE;
      end
      if (deq) begin
        rp <= rp + PTR_ONE;
      end
      case ({enq, deq})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (memwriteM && !enq) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Walk entries oldest to youngest so the last word match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rp + AW'(i);
      if ((CW'(i) < count) && (addr_q[fwd_idx][XLEN-1:2] == dataaddr[XLEN-1:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[fwd_idx];
      end
    end
  end

  assign readdata       = fwd_hit ? fwd_data : mem.mem_rdata;
  assign mem.mem_raddr  = dataaddr;
  assign mem.mem_wvalid = (count != '0);
  assign mem.mem_waddr  = addr_q[rp];
  assign mem.mem_wdata  = data_q[rp];
  assign sb_full        = (count == CNT_FULL);
  assign sb_empty       = (count == '0);
  assign sb_overflow    = overflow_q;

endmodule

// File: tb/tb_cpu6_store_buffer.sv
// Self-checking bench for cpu6_store_buffer: directed scenarios plus randomized traffic,
// compared against a queue-based model of the posted-write buffer.
module tb_cpu6_store_buffer;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } entry_t;

  logic        clk;
  logic        reset;
  logic        memwriteM;
  logic [31:0] dataaddr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        sb_full;
  logic        sb_empty;
  logic        sb_overflow;

  int     errors;
  int     checks;
  entry_t model_q[$];
  logic   model_ovf;

  cpu6_store_buffer_if #(.XLEN(XLEN)) mem_if ();

  cpu6_store_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk        (clk),
    .reset      (reset),
    .memwriteM  (memwriteM),
    .dataaddr   (dataaddr),
    .writedata  (writedata),
    .readdata   (readdata),
    .sb_full    (sb_full),
    .sb_empty   (sb_empty),
    .sb_overflow(sb_overflow),
    .mem        (mem_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] modelRead(input logic [31:0] addr, input logic [31:0] rdata);
    for (int i = model_q.size() - 1; i >= 0; i--) begin
      if (model_q[i].a[31:2] == addr[31:2]) return model_q[i].d;
    end
    return rdata;
  endfunction

  task automatic checkState(input logic [31:0] addr, input logic [31:0] rdata);
    checkOutput("readdata", readdata, modelRead(addr, rdata));
    checkOutput("mem_raddr", mem_if.mem_raddr, addr);
    checkOutput("mem_wvalid", 32'(mem_if.mem_wvalid), 32'(model_q.size() != 0));
    checkOutput("sb_full", 32'(sb_full), 32'(model_q.size() == DEPTH));
    checkOutput("sb_empty", 32'(sb_empty), 32'(model_q.size() == 0));
    checkOutput("sb_overflow", 32'(sb_overflow), 32'(model_ovf));
    if (model_q.size() != 0) begin
      checkOutput("mem_waddr", mem_if.mem_waddr, model_q[0].a);
      checkOutput("mem_wdata", mem_if.mem_wdata, model_q[0].d);
    end
  endtask

  // One cycle: drive after the falling edge, check, then advance the model on the rising edge.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                               input logic wr, input logic [31:0] rd);
    bit deq;
    bit enq;
    @(negedge clk);
    memwriteM         = we;
    dataaddr          = addr;
    writedata         = wd;
    mem_if.mem_wready = wr;
    mem_if.mem_rdata  = rd;
    #1;
    checkState(addr, rd);
    @(posedge clk);
    deq = (model_q.size() != 0) && wr;
    enq = we && ((model_q.size() < DEPTH) || deq);
    if (we && !enq) model_ovf = 1'b1;
    if (deq) void'(model_q.pop_front());
    if (enq) model_q.push_back('{a: addr, d: wd});
  endtask

  task automatic doReset(input int cycles);
    @(negedge clk);
    reset = 1'b0;
    model_q.delete();
    model_ovf = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      memwriteM         = 1'($urandom);
      dataaddr          = $urandom;
      writedata         = $urandom;
      mem_if.mem_wready = 1'($urandom);
      mem_if.mem_rdata  = $urandom;
      #1;
      checkOutput("rst_wvalid", 32'(mem_if.mem_wvalid), 32'd0);
      checkOutput("rst_empty", 32'(sb_empty), 32'd1);
      checkOutput("rst_full", 32'(sb_full), 32'd0);
      checkOutput("rst_overflow", 32'(sb_overflow), 32'd0);
      checkOutput("rst_waddr", mem_if.mem_waddr, 32'd0);
      checkOutput("rst_wdata", mem_if.mem_wdata, 32'd0);
      @(negedge clk);
    end
    memwriteM         = 1'b0;
    mem_if.mem_wready = 1'b1;
    reset             = 1'b1;
  endtask

  function automatic logic [31:0] randAddr();
    return (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    errors            = 0;
    checks            = 0;
    model_ovf         = 1'b0;
    reset             = 1'b0;
    memwriteM         = 1'b0;
    dataaddr          = '0;
    writedata         = '0;
    mem_if.mem_wready = 1'b0;
    mem_if.mem_rdata  = '0;

    doReset(3);
    repeat (3) applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h1234);

    // Posted write held off by memory for three cycles.
    applyStimulus(1'b1, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0);
    repeat (3) applyStimulus(1'b0, 32'h200, 32'h0, 1'b0, 32'h77);
    repeat (2) applyStimulus(1'b0, 32'h200, 32'h0, 1'b1, 32'h77);

    // Fill, then enqueue while draining so the pointers wrap.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'(i * 4), 32'hA0 + 32'(i), 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h10, 32'hA4, 1'b1, 32'h0);
    applyStimulus(1'b1, 32'h14, 32'hA5, 1'b1, 32'h0);
    repeat (5) applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h9);

    // Overflow is sticky across a full drain.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'(i * 4), 32'hB0 + 32'(i), 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h20, 32'hBAD, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h20, 32'h0, 1'b0, 32'h31);
    repeat (5) applyStimulus(1'b0, 32'h20, 32'h0, 1'b1, 32'h31);
    doReset(1);

    // Forwarding from the youngest matching store, then fall back to memory.
    applyStimulus(1'b1, 32'h40, 32'h1, 1'b0, 32'h55);
    applyStimulus(1'b1, 32'h40, 32'h2, 1'b0, 32'h55);
    applyStimulus(1'b0, 32'h40, 32'h0, 1'b0, 32'h55);
    applyStimulus(1'b0, 32'h42, 32'h0, 1'b0, 32'h55);
    applyStimulus(1'b0, 32'h44, 32'h0, 1'b0, 32'h55);
    repeat (2) applyStimulus(1'b0, 32'h40, 32'h0, 1'b1, 32'h55);
    applyStimulus(1'b0, 32'h40, 32'h0, 1'b1, 32'h66);

    // Simultaneous enqueue and dequeue at count one.
    applyStimulus(1'b1, 32'h80, 32'hC1, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h84, 32'hC2, 1'b1, 32'h0);
    applyStimulus(1'b0, 32'h84, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);

    // Randomized traffic with varying memory back-pressure.
    for (int seg = 0; seg < 8; seg++) begin
      int ready_pct;
      int store_pct;
      ready_pct = (seg % 4) * 30;
      store_pct = 40 + (seg % 3) * 25;
      for (int c = 0; c < 60; c++) begin
        applyStimulus(1'($urandom_range(0, 99) < store_pct), randAddr(), $urandom,
                      1'($urandom_range(0, 99) < ready_pct), $urandom);
      end
      if (seg == 5) doReset(1);
    end

    // Reset while stores are pending discards them immediately.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, randAddr(), $urandom, 1'b0, 32'h0);
    doReset(2);
    repeat (3) applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
